// File: rtl/bullet_engine.sv
// bullet_engine: multi-slot projectile manager for the playfield display path.
//
// Holds NUM_BULLETS independent bullet slots. Each slot has a position, a
// direction and a remaining lifetime. A rising edge on fire loads the
// lowest-index free slot at the ship origin, gated by a frame-based cooldown.
// Slots move SPEED pixels per frame (one frame_tick per synchronised vsync
// rise) and free on lifetime expiry or when the step would leave the screen.
// A registered per-pixel hit test drives bullet_on/bullet_id one cycle after
// DrawX/DrawY.
//
// Optional feature macro: BULLET_WRAP_EN -- off-screen steps wrap modulo
// 640 (X) / 480 (Y) instead of freeing the slot.
//
// Ports:
//   sys_clk      system clock
//   Reset        asynchronous active-high reset
//   vsync        VGA vertical sync (asynchronous level)
//   fire         fire request level, edge-detected
//   dir          fire direction: 0 up, 1 down, 2 left, 3 right
//   DrawX/DrawY  current pixel coordinates
//   bullet_on    pixel (one cycle earlier) is covered by an active bullet
//   bullet_id    lowest-index covering slot, 0 when bullet_on is 0
//   active_mask  per-slot active flags
//   fire_ack     one-cycle pulse: fire accepted
//   fire_drop    one-cycle pulse: fire rejected, no free slot
module bullet_engine #(
    parameter int unsigned NUM_BULLETS = 4,
    parameter int unsigned LIFETIME    = 64,
    parameter int unsigned SPEED       = 2,
    parameter int unsigned HALF_LEN    = 1,
    parameter int unsigned ORIGIN_X    = 320,
    parameter int unsigned ORIGIN_Y    = 240,
    parameter int unsigned COOLDOWN    = 8,
    localparam int unsigned IdW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
    input  logic                   sys_clk,
    input  logic                   Reset,
    input  logic                   vsync,
    input  logic                   fire,
    input  logic [1:0]             dir,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    output logic                   bullet_on,
    output logic [IdW-1:0]         bullet_id,
    output logic [NUM_BULLETS-1:0] active_mask,
    output logic                   fire_ack,
    output logic                   fire_drop
);

    localparam logic signed [10:0] Spd      = 11'(SPEED);
    localparam logic [10:0]        HalfLen  = 11'(HALF_LEN);
    localparam logic signed [10:0] XMax     = 11'sd639;
    localparam logic signed [10:0] YMax     = 11'sd479;
    localparam logic [9:0]         OriginX  = 10'(ORIGIN_X);
    localparam logic [9:0]         OriginY  = 10'(ORIGIN_Y);
    localparam logic [7:0]         LifeInit = 8'(LIFETIME);
    localparam logic [7:0]         CoolInit = 8'(COOLDOWN);

    logic                   vs_s1_q, vs_s2_q, vs_s3_q, tick_q, fire_q;
    logic [9:0]             x_q    [NUM_BULLETS];
    logic [9:0]             x_d    [NUM_BULLETS];
    logic [9:0]             y_q    [NUM_BULLETS];
    logic [9:0]             y_d    [NUM_BULLETS];
    logic [1:0]             dir_q  [NUM_BULLETS];
    logic [1:0]             dir_d  [NUM_BULLETS];
    logic [7:0]             life_q [NUM_BULLETS];
    logic [7:0]             life_d [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] act_q, act_d;
    logic [7:0]             cool_q, cool_d;
    logic                   ack_q, ack_d, drop_q, drop_d, on_q, on_d;
    logic [IdW-1:0]         id_q, id_d;
    logic                   fire_rise;

    assign fire_rise = fire & ~fire_q;

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            vs_s1_q <= 1'b0;
            vs_s2_q <= 1'b0;
            vs_s3_q <= 1'b0;
            tick_q  <= 1'b0;
            fire_q  <= 1'b0;
            act_q   <= '0;
            cool_q  <= '0;
            ack_q   <= 1'b0;
            drop_q  <= 1'b0;
            on_q    <= 1'b0;
            id_q    <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                dir_q[i]  <= '0;
                life_q[i] <= '0;
            end
        end else begin
            vs_s1_q <= vsync;
            vs_s2_q <= vs_s1_q;
            vs_s3_q <= vs_s2_q;
            // Rising edge of the synchronised vsync, registered once more.
            tick_q  <= vs_s2_q & ~vs_s3_q;
            fire_q  <= fire;
            act_q   <= act_d;
            cool_q  <= cool_d;
            ack_q   <= ack_d;
            drop_q  <= drop_d;
            on_q    <= on_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            life_q  <= life_d;
        end
    end

    // Slot motion, expiry, allocation and cooldown.
    always_comb begin
        logic signed [10:0] nx, ny;
        logic               free_found;
        logic [IdW-1:0]     free_idx;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        life_d     = life_q;
        act_d      = act_q;
        cool_d     = cool_q;
        ack_d      = 1'b0;
        drop_d     = 1'b0;
        nx         = '0;
        ny         = '0;
        free_found = 1'b0;
        free_idx   = '0;

        // Free-slot search uses pre-tick occupancy: a slot freed this cycle
        // is not reused until the next one.
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!act_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdW'(i);
            end
        end

        if (tick_q) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (act_q[i]) begin
                    nx = signed'({1'b0, x_q[i]});
                    ny = signed'({1'b0, y_q[i]});
                    case (dir_q[i])
                        2'd0:    ny = ny - Spd;
                        2'd1:    ny = ny + Spd;
                        2'd2:    nx = nx - Spd;
                        default: nx = nx + Spd;
                    endcase
                    life_d[i] = life_q[i] - 8'd1;
`ifdef BULLET_WRAP_EN
                    if (nx < 11'sd0) begin
                        nx = nx + 11'sd640;
                    end else if (nx > XMax) begin
                        nx = nx - 11'sd640;
                    end
                    if (ny < 11'sd0) begin
                        ny = ny + 11'sd480;
                    end else if (ny > YMax) begin
                        ny = ny - 11'sd480;
                    end
                    if (life_q[i] == 8'd1) begin
                        act_d[i] = 1'b0;
                    end
`else
                    if (life_q[i] == 8'd1 || nx < 11'sd0 || nx > XMax ||
                        ny < 11'sd0 || ny > YMax) begin
                        act_d[i] = 1'b0;
                    end
`endif
                    x_d[i] = nx[9:0];
                    y_d[i] = ny[9:0];
                end
            end
        end

        if (tick_q && cool_q != 8'd0) begin
            cool_d = cool_q - 8'd1;
        end

        // A fire during cooldown is silently ignored (neither ack nor drop).
        if (fire_rise && cool_q == 8'd0) begin
            if (free_found) begin
                x_d[free_idx]    = OriginX;
                y_d[free_idx]    = OriginY;
                dir_d[free_idx]  = dir;
                life_d[free_idx] = LifeInit;
                act_d[free_idx]  = 1'b1;
                ack_d            = 1'b1;
                cool_d           = CoolInit;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    // Per-pixel hit test; compares are arranged to avoid subtraction underflow.
    always_comb begin
        logic cov;
        on_d = 1'b0;
        id_d = '0;
        cov  = 1'b0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!dir_q[i][1]) begin
                cov = (DrawX == x_q[i]) &&
                      ({1'b0, y_q[i]} + HalfLen >= {1'b0, DrawY}) &&
                      ({1'b0, DrawY} + HalfLen >= {1'b0, y_q[i]});
            end else begin
                cov = (DrawY == y_q[i]) &&
                      ({1'b0, x_q[i]} + HalfLen >= {1'b0, DrawX}) &&
                      ({1'b0, DrawX} + HalfLen >= {1'b0, x_q[i]});
            end
            if (act_q[i] && cov) begin
                on_d = 1'b1;
                id_d = IdW'(i);
            end
        end
    end

    assign bullet_on   = on_q;
    assign bullet_id   = id_q;
    assign active_mask = act_q;
    assign fire_ack    = ack_q;
    assign fire_drop   = drop_q;

endmodule

// File: tb/tb_bullet_engine.sv
// tb_bullet_engine: two bullet_engine instances share one stimulus stream.
// u_a uses default parameters; u_b spawns near the right/top edges with a
// long lifetime and no cooldown so the screen-edge and overlap cases are
// reachable. A behavioural model predicts every output each cycle.
module tb_bullet_engine;

    localparam int NB = 4;
    localparam int HL = 1;
    localparam int SP = 2;
`ifdef BULLET_WRAP_EN
    localparam int ES = 3;
`else
    localparam int ES = 2;
`endif

    logic       clk, rst, vsync, fire;
    logic [1:0] dir;
    logic [9:0] DrawX, DrawY;
    logic       on_a, on_b, ack_a, ack_b, drop_a, drop_b;
    logic [1:0] id_a, id_b;
    logic [3:0] mask_a, mask_b;

    int n_vec = 0;
    int n_err = 0;

    bullet_engine u_a (
        .sys_clk(clk), .Reset(rst), .vsync(vsync), .fire(fire), .dir(dir),
        .DrawX(DrawX), .DrawY(DrawY), .bullet_on(on_a), .bullet_id(id_a),
        .active_mask(mask_a), .fire_ack(ack_a), .fire_drop(drop_a)
    );

    bullet_engine #(
        .ORIGIN_X(630), .ORIGIN_Y(6), .LIFETIME(255), .COOLDOWN(0)
    ) u_b (
        .sys_clk(clk), .Reset(rst), .vsync(vsync), .fire(fire), .dir(dir),
        .DrawX(DrawX), .DrawY(DrawY), .bullet_on(on_b), .bullet_id(id_b),
        .active_mask(mask_b), .fire_ack(ack_b), .fire_drop(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int  mx [2][NB];
    int  my [2][NB];
    int  md [2][NB];
    int  ml [2][NB];
    bit  ma [2][NB];
    int  mc [2];
    bit  vh [4];
    bit  fprev;
    bit  e_on [2];
    bit  e_ack [2];
    bit  e_drop [2];
    int  e_id [2];

    function automatic int pox(input int u);  return (u == 0) ? 320 : 630; endfunction
    function automatic int poy(input int u);  return (u == 0) ? 240 : 6;   endfunction
    function automatic int plife(input int u); return (u == 0) ? 64 : 255; endfunction
    function automatic int pcool(input int u); return (u == 0) ? 8 : 0;    endfunction

    function automatic bit covers(input int u, input int s, input int px, input int py);
        if (!ma[u][s]) return 1'b0;
        if (md[u][s] <= 1)
            return (px == mx[u][s]) && (py - my[u][s] <= HL) && (my[u][s] - py <= HL);
        return (py == my[u][s]) && (px - mx[u][s] <= HL) && (mx[u][s] - px <= HL);
    endfunction

    function automatic int m_mask(input int u);
        int m = 0;
        for (int s = 0; s < NB; s++) if (ma[u][s]) m = m | (1 << s);
        return m;
    endfunction

    task automatic model_clear();
        for (int u = 0; u < 2; u++) begin
            for (int s = 0; s < NB; s++) begin
                ma[u][s] = 1'b0; mx[u][s] = 0; my[u][s] = 0; md[u][s] = 0; ml[u][s] = 0;
            end
            mc[u] = 0; e_on[u] = 1'b0; e_id[u] = 0; e_ack[u] = 1'b0; e_drop[u] = 1'b0;
        end
        for (int k = 0; k < 4; k++) vh[k] = 1'b0;
        fprev = 1'b0;
    endtask

    task automatic model_step();
        bit tick, rise;
        int fs, nx, ny;
        // A frame takes effect four edges after vsync is first sampled high.
        tick = vh[2] && !vh[3];
        rise = fire && !fprev;
        for (int u = 0; u < 2; u++) begin
            e_on[u] = 1'b0; e_id[u] = 0; e_ack[u] = 1'b0; e_drop[u] = 1'b0;
            for (int s = NB - 1; s >= 0; s--)
                if (covers(u, s, int'(DrawX), int'(DrawY))) begin
                    e_on[u] = 1'b1; e_id[u] = s;
                end
            fs = -1;
            for (int s = NB - 1; s >= 0; s--) if (!ma[u][s]) fs = s;
            if (tick) begin
                for (int s = 0; s < NB; s++) begin
                    if (ma[u][s]) begin
                        nx = mx[u][s]; ny = my[u][s];
                        if (md[u][s] == 0) ny = ny - SP;
                        else if (md[u][s] == 1) ny = ny + SP;
                        else if (md[u][s] == 2) nx = nx - SP;
                        else nx = nx + SP;
                        ml[u][s] = ml[u][s] - 1;
`ifdef BULLET_WRAP_EN
                        nx = (nx + 640) % 640;
                        ny = (ny + 480) % 480;
                        if (ml[u][s] == 0) ma[u][s] = 1'b0;
`else
                        if (ml[u][s] == 0 || nx < 0 || nx > 639 || ny < 0 || ny > 479)
                            ma[u][s] = 1'b0;
`endif
                        mx[u][s] = nx; my[u][s] = ny;
                    end
                end
            end
            if (rise && mc[u] == 0) begin
                if (fs >= 0) begin
                    mx[u][fs] = pox(u); my[u][fs] = poy(u); md[u][fs] = int'(dir);
                    ml[u][fs] = plife(u); ma[u][fs] = 1'b1;
                    e_ack[u] = 1'b1; mc[u] = pcool(u);
                end else begin
                    e_drop[u] = 1'b1;
                end
            end else if (tick && mc[u] > 0) begin
                mc[u] = mc[u] - 1;
            end
        end
        vh[3] = vh[2]; vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = vsync;
        fprev = fire;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_clear();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_mask_a", int'(mask_a), m_mask(0));
            chk("cyc_on_a",   int'(on_a),   int'(e_on[0]));
            chk("cyc_id_a",   int'(id_a),   e_id[0]);
            chk("cyc_ack_a",  int'(ack_a),  int'(e_ack[0]));
            chk("cyc_drop_a", int'(drop_a), int'(e_drop[0]));
            chk("cyc_mask_b", int'(mask_b), m_mask(1));
            chk("cyc_on_b",   int'(on_b),   int'(e_on[1]));
            chk("cyc_id_b",   int'(id_b),   e_id[1]);
            chk("cyc_ack_b",  int'(ack_b),  int'(e_ack[1]));
            chk("cyc_drop_b", int'(drop_b), int'(e_drop[1]));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic frame();
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    // Fire rise lands on the same edge as the frame update.
    task automatic frame_fire(input int d);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0; fire = 1'b1; dir = 2'(d);
        @(negedge clk);
        fire = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_fire(input int d, input int ea, input int ed);
        dir = 2'(d); fire = 1'b1;
        @(negedge clk);
        chk("lit_ack_a", int'(ack_a), ea);
        chk("lit_drop_a", int'(drop_a), ed);
        fire = 1'b0;
        @(negedge clk);
        chk("lit_ack_a_pulse", int'(ack_a), 0);
    endtask

    task automatic probe(input int u, input int x, input int y, input int eon, input int eid);
        DrawX = 10'(x); DrawY = 10'(y);
        @(negedge clk);
        if (u == 0) begin
            chk("lit_on_a", int'(on_a), eon);
            chk("lit_id_a", int'(id_a), eid);
        end else begin
            chk("lit_on_b", int'(on_b), eon);
            chk("lit_id_b", int'(id_b), eid);
        end
    endtask

    initial begin
        rst = 1'b0; vsync = 1'b0; fire = 1'b0; dir = 2'd0; DrawX = '0; DrawY = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("lit_rst_mask_a", int'(mask_a), 0);
        chk("lit_rst_on_a", int'(on_a), 0);

        // Single up-fire and motion over three frames.
        do_fire(0, 1, 0);
        chk("lit_mask_a_1", int'(mask_a), 1);
        chk("lit_mask_b_1", int'(mask_b), 1);
        frames(3);
        chk("mdl_x_a0", mx[0][0], 320);
        chk("mdl_y_a0", my[0][0], 234);
        probe(0, 320, 233, 1, 0);
        probe(0, 320, 234, 1, 0);
        probe(0, 320, 235, 1, 0);
        probe(0, 320, 236, 0, 0);
        probe(0, 320, 232, 0, 0);
        probe(0, 321, 234, 0, 0);
        DrawX = '0; DrawY = '0;

        // Fire during cooldown on u_a; u_b has no cooldown and accepts.
        do_fire(1, 0, 0);
        chk("lit_ack_b_nocool", int'(mask_b), 3);
        frame();
`ifdef BULLET_WRAP_EN
        chk("lit_b_top_wrap", int'(mask_b[0]), 1);
        chk("mdl_b_top_wrap", my[1][0], 478);
`else
        chk("lit_b_top_free", int'(mask_b[0]), 0);
`endif
        frames(4);
        chk("mdl_cool_a", mc[0], 0);

        do_fire(2, 1, 0);
        chk("lit_mask_a_2", int'(mask_a), 3);
        frames(8);
        do_fire(3, 1, 0);
        chk("lit_mask_a_3", int'(mask_a), 7);
        frames(4);
        chk("mdl_b_edge_x", mx[1][ES], 638);
        chk("lit_b_edge_live", int'(mask_b[ES]), 1);
        frame();
`ifdef BULLET_WRAP_EN
        chk("lit_b_edge_wrap", int'(mask_b[ES]), 1);
        chk("mdl_b_edge_wrap", mx[1][ES], 0);
`else
        chk("lit_b_edge_free", int'(mask_b[ES]), 0);
`endif
        frames(3);
        do_fire(1, 1, 0);
        chk("lit_mask_a_full", int'(mask_a), 15);
        frames(8);

        // Fifth fire with all slots busy.
        do_fire(0, 0, 1);
        chk("lit_mask_a_full2", int'(mask_a), 15);

        // Lifetime: slot0 has 32 frames behind it.
        frames(31);
        chk("lit_life63_a", int'(mask_a[0]), 1);
        chk("mdl_life63_a", ml[0][0], 1);
        frame_fire(2);
        chk("lit_life64_a", int'(mask_a), 14);

        // Mid-flight reset with three live bullets; slot3 sits at (320,320).
        probe(0, 320, 320, 1, 3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("lit_async_mask_a", int'(mask_a), 0);
        chk("lit_async_on_a", int'(on_a), 0);
        chk("lit_async_mask_b", int'(mask_b), 0);
        chk("lit_async_drop_a", int'(drop_a), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        DrawX = '0; DrawY = '0;
        do_fire(0, 1, 0);
        chk("lit_postrst_ack_mask", int'(mask_a), 1);

        // Overlap on u_b: two bullets at its origin.
        do_fire(1, 0, 0);
        chk("lit_mask_b_pair", int'(mask_b), 3);
        probe(1, 630, 6, 1, 0);
        probe(0, 630, 6, 0, 0);
        probe(0, 320, 240, 1, 0);

        // Fire coinciding with a frame update.
        frame_fire(2);
        chk("mdl_b_s0_y", my[1][0], 4);
        chk("mdl_b_s1_y", my[1][1], 8);
        chk("mdl_b_s2_y", my[1][2], 6);
        chk("mdl_b_s2_x", mx[1][2], 630);
        chk("mdl_a_s0_y", my[0][0], 238);
        probe(1, 630, 6, 1, 2);
        probe(1, 631, 6, 1, 2);
        probe(1, 630, 4, 1, 0);
        probe(1, 630, 8, 1, 1);
        probe(0, 320, 239, 1, 0);
        DrawX = '0; DrawY = '0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
